// File: rtl/mem_responder.sv
// Wait-state memory responder: a single-port word array behind an
// IDLE/WAIT/ACCESS/DONE handshake with a one-cycle mem_ready completion pulse.
module mem_responder #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rm,
  input  logic              wmem,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_ready,
  output logic              busy,
  output logic              err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_LAST =
    (WAIT_CYCLES == 0) ? CNT_W'(0) : CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_start;
  logic                w_err_nxt;

  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_is_wr;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_mem_ready;
  logic                r_busy;
  logic                r_err;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  // Next-state and wait-counter logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_start     = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (rm ^ wmem) begin
          w_start     = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
        end else if (rm && wmem) begin
          w_err_nxt = 1'b1;
        end
      end
      WAIT: begin
        if (r_cnt == WAIT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ACCESS;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ACCESS:  w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, request latches and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_is_wr     <= 1'b0;
      r_rdata     <= '0;
      r_mem_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mem_ready <= (w_state_nxt == DONE);
      r_busy      <= (w_state_nxt != IDLE);
      r_err       <= w_err_nxt;
      if (w_start) begin
        r_addr  <= addr;
        r_wdata <= wdata;
        r_is_wr <= wmem;
      end
      if (r_state == ACCESS && !r_is_wr) begin
        r_rdata <= r_mem[r_addr];
      end
    end
  end

  // Array has no reset; an aborted access never reaches ACCESS so it cannot write
  always_ff @(posedge clk) begin
    if (r_state == ACCESS && r_is_wr) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  assign rdata     = r_rdata;
  assign mem_ready = r_mem_ready;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder with WAIT_CYCLES=2 and
// WAIT_CYCLES=0 instances sharing clock and reset.
module tb_mem_responder;

  logic        clk;
  logic        reset;
  logic        rm, wmem;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        mem_ready, busy, err;
  logic        rm0, wmem0;
  logic [7:0]  addr0;
  logic [15:0] wdata0;
  logic [15:0] rdata0;
  logic        mem_ready0, busy0, err0;

  int n_checks;
  int n_fail;

  mem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .reset(reset), .rm(rm), .wmem(wmem), .addr(addr), .wdata(wdata),
    .rdata(rdata), .mem_ready(mem_ready), .busy(busy), .err(err)
  );

  mem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .rm(rm0), .wmem(wmem0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .mem_ready(mem_ready0), .busy(busy0), .err(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One WAIT_CYCLES=2 access; edge 0 is the sampling edge
  task automatic access2(input logic wr, input logic [7:0] a, input logic [15:0] d,
                         input string tag);
    rm    = ~wr;
    wmem  = wr;
    addr  = a;
    wdata = d;
    tick();
    rm   = 1'b0;
    wmem = 1'b0;
    check({tag, "_busy_e0"}, 32'(busy), 32'd1);
    check({tag, "_rdy_e0"}, 32'(mem_ready), 32'd0);
    for (int e = 1; e <= 4; e++) begin
      tick();
      check($sformatf("%s_rdy_e%0d", tag, e), 32'(mem_ready), (e == 3) ? 32'd1 : 32'd0);
      check($sformatf("%s_busy_e%0d", tag, e), 32'(busy), (e < 4) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rm = 1'b0; wmem = 1'b0; addr = '0; wdata = '0;
    rm0 = 1'b0; wmem0 = 1'b0; addr0 = '0; wdata0 = '0;
    reset = 1'b1;
    tick();
    tick();
    check("rst_rdata", 32'(rdata), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rdy", 32'(mem_ready), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_busy0", 32'(busy0), 32'h0);
    reset = 1'b0;
    tick();

    // Zero-wait instance: write 0x1234 to 0x00 then read it back
    wmem0 = 1'b1; addr0 = 8'h00; wdata0 = 16'h1234;
    tick();
    wmem0 = 1'b0; wdata0 = 16'h0;
    check("w0_busy_e0", 32'(busy0), 32'd1);
    check("w0_rdy_e0", 32'(mem_ready0), 32'd0);
    tick();
    check("w0_rdy_e1", 32'(mem_ready0), 32'd1);
    tick();
    check("w0_rdy_e2", 32'(mem_ready0), 32'd0);
    check("w0_busy_e2", 32'(busy0), 32'd0);
    check("w0_rdata_unchanged", 32'(rdata0), 32'h0);
    rm0 = 1'b1;
    tick();
    rm0 = 1'b0;
    check("r0_rdy_e0", 32'(mem_ready0), 32'd0);
    tick();
    check("r0_rdy_e1", 32'(mem_ready0), 32'd1);
    check("r0_rdata", 32'(rdata0), 32'h1234);
    tick();
    check("r0_rdy_e2", 32'(mem_ready0), 32'd0);

    // Basic write/read with two wait states
    access2(1'b1, 8'h10, 16'hBEEF, "wr10");
    check("wr10_rdata_unchanged", 32'(rdata), 32'h0);
    access2(1'b0, 8'h10, 16'h0000, "rd10");
    check("rd10_rdata", 32'(rdata), 32'hBEEF);

    // Conflicting request: error pulse, nothing else happens
    rm = 1'b1; wmem = 1'b1; addr = 8'h10; wdata = 16'h0BAD;
    tick();
    rm = 1'b0; wmem = 1'b0;
    check("conf_err", 32'(err), 32'd1);
    check("conf_busy", 32'(busy), 32'd0);
    check("conf_rdy", 32'(mem_ready), 32'd0);
    check("conf_rdata", 32'(rdata), 32'hBEEF);
    tick();
    check("conf_err_clear", 32'(err), 32'd0);
    check("conf_busy_after", 32'(busy), 32'd0);
    access2(1'b1, 8'h01, 16'h0101, "wr01");
    access2(1'b0, 8'h10, 16'h0000, "rd10b");
    check("conf_array_kept", 32'(rdata), 32'hBEEF);

    // Inputs changing during WAIT are ignored
    access2(1'b1, 8'h06, 16'h0606, "wr06");
    wmem = 1'b1; addr = 8'h05; wdata = 16'hAAAA;
    tick();
    wmem = 1'b0; addr = 8'h06; wdata = 16'h5555;
    tick();
    rm = 1'b1; wmem = 1'b1;
    tick();
    rm = 1'b0; wmem = 1'b0;
    check("chg_no_err", 32'(err), 32'd0);
    tick();
    check("chg_rdy_e3", 32'(mem_ready), 32'd1);
    tick();
    check("chg_idle_e4", 32'(busy), 32'd0);
    check("chg_rdata_unchanged", 32'(rdata), 32'hBEEF);
    access2(1'b0, 8'h05, 16'h0, "rd05");
    check("chg_rd05", 32'(rdata), 32'hAAAA);
    access2(1'b0, 8'h06, 16'h0, "rd06");
    check("chg_rd06", 32'(rdata), 32'h0606);

    // Reset during WAIT cancels the write
    access2(1'b1, 8'h20, 16'h0001, "wr20");
    wmem = 1'b1; addr = 8'h20; wdata = 16'hFFFF;
    tick();
    wmem = 1'b0;
    tick();
    check("abort_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rdata", 32'(rdata), 32'h0);
    check("abort_rdy", 32'(mem_ready), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    rm = 1'b1;
    tick();
    tick();
    check("rst_ignores_req", 32'(busy), 32'd0);
    check("rst_ignores_rdy", 32'(mem_ready), 32'd0);
    rm = 1'b0;
    reset = 1'b0;
    tick();
    access2(1'b0, 8'h20, 16'h0, "rd20");
    check("abort_old_value", 32'(rdata), 32'h0001);

    // Continuous read request: pulse every WAIT_CYCLES+3 cycles
    access2(1'b1, 8'hFF, 16'hC3C3, "wrFF");
    rm = 1'b1; addr = 8'hFF;
    for (int e = 0; e <= 14; e++) begin
      tick();
      check($sformatf("cont_rdy_e%0d", e), 32'(mem_ready), ((e % 5) == 3) ? 32'd1 : 32'd0);
    end
    rm = 1'b0;
    check("cont_rdata", 32'(rdata), 32'hC3C3);
    tick();
    check("cont_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The module SHALL have parameter DATA_W, default 16, data word width.
REQ-002 The module SHALL have parameter ADDR_W, default 8, word address width; array depth is 2**ADDR_W.
REQ-003 The module SHALL have parameter WAIT_CYCLES, default 2, legal range 0..15, number of wait states before each access.
REQ-004 The module SHALL have port clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-005 The module SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 The module SHALL have port rm  input  1  read request from the controller.
REQ-007 The module SHALL have port wmem  input  1  write request from the controller.
REQ-008 The module SHALL have port addr  input  ADDR_W  word address, driven from MAR.
REQ-009 The module SHALL have port wdata  input  DATA_W  write data, driven from MDR.
REQ-010 The module SHALL have port rdata  output  DATA_W  read data, returned to MDR.
REQ-011 The module SHALL have port mem_ready  output  1  one-cycle completion pulse.
REQ-012 The module SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-013 The module SHALL have port err  output  1  one-cycle pulse on an illegal request.

Function
REQ-014 The FSM SHALL have four states: IDLE, WAIT, ACCESS and DONE.
REQ-015 In IDLE, a request SHALL be sampled on a rising edge when exactly one of rm or wmem is high; that edge SHALL latch addr, wdata and the operation type.
REQ-016 On the sampling edge, the next state SHALL be WAIT if WAIT_CYCLES>0, otherwise ACCESS.
REQ-017 WAIT SHALL last exactly WAIT_CYCLES cycles, counted by an internal counter, then move to ACCESS.
REQ-018 ACCESS SHALL last one cycle. On the edge leaving ACCESS, a write SHALL store the latched wdata at the latched address, and a read SHALL load rdata from the array at the latched address.
REQ-019 DONE SHALL last one cycle with mem_ready=1, then return to IDLE. mem_ready SHALL be 0 in every other state.
REQ-020 Latency: with the sampling edge as edge 0, mem_ready SHALL be high from edge WAIT_CYCLES+1 to edge WAIT_CYCLES+2.
REQ-021 rdata SHALL hold its value until the next read completes; a write SHALL NOT change rdata.
REQ-022 Changes on rm, wmem, addr or wdata while busy=1 SHALL be ignored; only latched values are used.
REQ-023 If rm and wmem are both high while in IDLE: no access is performed, err=1 for one cycle, and the state stays IDLE.
REQ-024 A request that is held high through DONE SHALL be re-sampled as a new request on the first edge in IDLE; back-to-back accesses are allowed with one IDLE cycle between them.
REQ-025 Every address 0..2**ADDR_W-1 SHALL be valid; there is no out-of-range case.
REQ-026 A read SHALL return the data of a write to the same address that completed earlier.

Reset
REQ-027 When reset is asserted, the module SHALL immediately enter IDLE and set the wait counter to 0, rdata=0, mem_ready=0, busy=0 and err=0.
REQ-028 Array contents SHALL NOT be cleared by reset.
REQ-029 Reset asserted in WAIT or ACCESS, before the edge that leaves ACCESS, SHALL cancel the access: no array write and no rdata update.
REQ-030 While reset is high, requests SHALL be ignored.

Verification
REQ-031 Scenario: WAIT_CYCLES=2; write addr=0x10, wdata=0xBEEF; then read addr=0x10 -> mem_ready high from edge 3 to edge 4 for each access, busy high from edge 0 to edge 4, read returns rdata=0xBEEF.
REQ-032 Scenario: WAIT_CYCLES=0; read addr=0x00 after writing 0x1234 to it -> mem_ready high from edge 1 to edge 2, rdata=0x1234.
REQ-033 Scenario: rm=1 and wmem=1 together in IDLE -> err pulses for one cycle, busy=0, mem_ready=0, array and rdata unchanged.
REQ-034 Scenario: write 0xAAAA to 0x05; change addr to 0x06 and wdata to 0x5555 during WAIT -> 0xAAAA is at 0x05 and 0x06 is unchanged.
REQ-035 Scenario: start write 0xFFFF to 0x20 (old value 0x0001); assert reset in WAIT -> all outputs 0, state IDLE; a later read of 0x20 returns 0x0001.
REQ-036 Scenario: hold rm=1 continuously with addr=0xFF -> repeated reads, with mem_ready pulses every WAIT_CYCLES+3 cycles.
